cla16_pp_sub: RTL



---
 rtl/cla16_pp_sub.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/cla16_pp_sub.sv
// cla16_pp_sub: 16-bit pipelined carry-lookahead subtractor, d = a - b - bin.
// The datapath computes a + ~b + ~bin, so it reuses the adder's 4-bit
// group/block lookahead. The unsigned borrow is the inverted carry-out.
// Four register stages give a latency of 4 (accepted at edge N, result
// presented after edge N+3). A global stall freezes every stage while
// out_valid && !out_ready.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready is combinational)
//   a, b, bin            minuend, subtrahend, borrow in
//   out_valid/out_ready  result handshake
//   d, bout, ovf, zero   difference, unsigned borrow out, signed overflow,
//                        zero flag (all registered)
//
// Optional build macro CLA16_SUB_SAT_EN: when it is defined, unsigned
// underflow clamps d to 16'h0000 (zero=1). bout and ovf still report the
// raw condition.
module cla16_pp_sub #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] d,
  output logic         bout,
  output logic         ovf,
  output logic         zero
);

  localparam int LAT = 4;

  // The lookahead tree is built for exactly four 4-bit groups.
  if (W != 16 || LAT != 4) begin : g_width_check
    $error("cla16_pp_sub supports only W=16");
  end

  // Carries c0..c3 of a 4-bit group, given its carry-in.
  function automatic logic [3:0] cla4_carries(input logic [3:0] p,
                                              input logic [3:0] g,
                                              input logic       ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  // Group generate/propagate of a 4-bit group, returned as {gg, gp}.
  function automatic logic [1:0] cla4_group(input logic [3:0] p,
                                            input logic [3:0] g);
    logic gg;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {gg, &p};
  endfunction

  logic w_en;

  // Stage 1 registers
  logic        r1_v;
  logic [15:0] r1_a;
  logic [15:0] r1_nb;
  logic        r1_cin;

  // Stage 2 combinational and registers
  logic [15:0] w2_p;
  logic [15:0] w2_g;
  logic [3:0]  w2_gp;
  logic [3:0]  w2_gg;
  logic [3:0]  w2_c0;
  logic        r2_v;
  logic [15:0] r2_p;
  logic [15:4] r2_g;   // group 0 carries are already resolved in stage 2
  logic [3:0]  r2_gp;
  logic [3:0]  r2_gg;
  logic [3:0]  r2_c0;  // c0 (= cin) .. c3
  logic        r2_a15;
  logic        r2_b15;

  // Stage 3 combinational and registers
  logic        w3_c4;
  logic        w3_c8;
  logic        w3_c12;
  logic        w3_c16;
  logic [16:0] w3_c;
  logic        r3_v;
  logic [15:0] r3_p;
  logic [16:0] r3_c;
  logic        r3_a15;
  logic        r3_b15;

  // Stage 4 combinational and output registers
  logic [15:0] w4_d_raw;
  logic [15:0] w4_d;
  logic        w4_bout;
  logic        w4_ovf;
  logic        w4_zero;
  logic        r_out_valid;
  logic [15:0] r_d;
  logic        r_bout;
  logic        r_ovf;
  logic        r_zero;

  // One enable for the whole pipe: it moves unless a result is stuck at the output.
  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  // Stage 1: capture a, ~b and ~bin. The inversions turn a subtraction into an addition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v   <= 1'b0;
      r1_a   <= 16'h0000;
      r1_nb  <= 16'h0000;
      r1_cin <= 1'b0;
    end else if (w_en) begin
      r1_v   <= in_valid;
      r1_a   <= a;
      r1_nb  <= ~b;
      r1_cin <= ~bin;
    end
  end

  assign w2_p = r1_a ^ r1_nb;
  assign w2_g = r1_a & r1_nb;
  assign {w2_gg[0], w2_gp[0]} = cla4_group(w2_p[3:0],   w2_g[3:0]);
  assign {w2_gg[1], w2_gp[1]} = cla4_group(w2_p[7:4],   w2_g[7:4]);
  assign {w2_gg[2], w2_gp[2]} = cla4_group(w2_p[11:8],  w2_g[11:8]);
  assign {w2_gg[3], w2_gp[3]} = cla4_group(w2_p[15:12], w2_g[15:12]);
  assign w2_c0 = cla4_carries(w2_p[3:0], w2_g[3:0], r1_cin);

  // Stage 2: register the bit p/g, the group gp/gg and the group 0 carries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_v   <= 1'b0;
      r2_p   <= 16'h0000;
      r2_g   <= 12'h000;
      r2_gp  <= 4'h0;
      r2_gg  <= 4'h0;
      r2_c0  <= 4'h0;
      r2_a15 <= 1'b0;
      r2_b15 <= 1'b0;
    end else if (w_en) begin
      r2_v   <= r1_v;
      r2_p   <= w2_p;
      r2_g   <= w2_g[15:4];
      r2_gp  <= w2_gp;
      r2_gg  <= w2_gg;
      r2_c0  <= w2_c0;
      r2_a15 <= r1_a[15];
      r2_b15 <= ~r1_nb[15];
    end
  end

  // Group-level chain, then the internal carries of groups 1-3 from their group carry-in.
  assign w3_c4  = r2_gg[0] | (r2_gp[0] & r2_c0[0]);
  assign w3_c8  = r2_gg[1] | (r2_gp[1] & w3_c4);
  assign w3_c12 = r2_gg[2] | (r2_gp[2] & w3_c8);
  assign w3_c16 = r2_gg[3] | (r2_gp[3] & w3_c12);
  assign w3_c   = {w3_c16,
                   cla4_carries(r2_p[15:12], r2_g[15:12], w3_c12),
                   cla4_carries(r2_p[11:8],  r2_g[11:8],  w3_c8),
                   cla4_carries(r2_p[7:4],   r2_g[7:4],   w3_c4),
                   r2_c0};

  // Stage 3: register p and the full carry vector c[16:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_v   <= 1'b0;
      r3_p   <= 16'h0000;
      r3_c   <= 17'h00000;
      r3_a15 <= 1'b0;
      r3_b15 <= 1'b0;
    end else if (w_en) begin
      r3_v   <= r2_v;
      r3_p   <= r2_p;
      r3_c   <= w3_c;
      r3_a15 <= r2_a15;
      r3_b15 <= r2_b15;
    end
  end

  assign w4_d_raw = r3_p ^ r3_c[15:0];
  assign w4_bout  = ~r3_c[16];
  assign w4_ovf   = (r3_a15 ^ r3_b15) & (w4_d_raw[15] ^ r3_a15);
`ifdef CLA16_SUB_SAT_EN
  assign w4_d     = w4_bout ? 16'h0000 : w4_d_raw;
`else
  assign w4_d     = w4_d_raw;
`endif
  assign w4_zero  = ~|w4_d;

  // Stage 4: valid moves with every enabled edge; the result only changes when a valid beat lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_d         <= 16'h0000;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= r3_v;
      if (r3_v) begin
        r_d    <= w4_d;
        r_bout <= w4_bout;
        r_ovf  <= w4_ovf;
        r_zero <= w4_zero;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign d         = r_d;
  assign bout      = r_bout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule
